// File: rtl/seq_bit_serializer.sv
// Parallel-in, MSB-first serial-out pattern feeder with per-bit hold divider and strobe.
// Optional feature: define SERIAL_LOOP_EN to repeat the pattern until STOP is seen.
module seq_bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIV_CYCLES = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       LOAD,
`ifdef SERIAL_LOOP_EN
    input  logic                       STOP,
`endif
    input  logic [WIDTH-1:0]           PATTERN,
    output logic                       BIT_OUT,
    output logic                       BIT_STROBE,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [$clog2(WIDTH+1)-1:0] bitCount
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned DW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             bit_q, bit_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    div_q, div_d;
`ifdef SERIAL_LOOP_EN
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             stop_seen_q, stop_seen_d;
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        div_d    = div_q;
`ifdef SERIAL_LOOP_EN
        pat_d       = pat_q;
        stop_seen_d = stop_seen_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (LOAD) begin
                    shreg_d  = PATTERN;
                    bit_d    = PATTERN[WIDTH-1];
                    strobe_d = 1'b1;
                    cnt_d    = CW'(1);
                    div_d    = '0;
                    state_d  = ST_SHIFT;
`ifdef SERIAL_LOOP_EN
                    pat_d       = PATTERN;
                    stop_seen_d = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
`ifdef SERIAL_LOOP_EN
                stop_seen_d = stop_seen_q | STOP;
`endif
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DW'(1);
                end else if (cnt_q != CNT_LAST) begin
                    shreg_d  = shreg_q << 1;
                    bit_d    = shreg_q[WIDTH-2];
                    strobe_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    div_d    = '0;
                end else begin
                    state_d = ST_DONE;
                    bit_d   = 1'b0;
                    done_d  = 1'b1;
                    div_d   = '0;
`ifdef SERIAL_LOOP_EN
                    // No STOP this pass: restart from the captured pattern without a gap.
                    if (!(stop_seen_q | STOP)) begin
                        state_d     = ST_SHIFT;
                        shreg_d     = pat_q;
                        bit_d       = pat_q[WIDTH-1];
                        strobe_d    = 1'b1;
                        cnt_d       = CW'(1);
                        stop_seen_d = 1'b0;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bit_q    <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            div_q    <= '0;
`ifdef SERIAL_LOOP_EN
            pat_q       <= '0;
            stop_seen_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
`ifdef SERIAL_LOOP_EN
            pat_q       <= pat_d;
            stop_seen_q <= stop_seen_d;
`endif
        end
    end

    assign BIT_OUT    = bit_q;
    assign BIT_STROBE = strobe_q;
    assign BUSY       = (state_q == ST_SHIFT);
    assign DONE       = done_q;
    assign bitCount   = cnt_q;

endmodule
